// File: rtl/wisc_fetch_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
package wisc_fetch_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 16;
    localparam int unsigned CTR_W  = 2;

    localparam logic [INST_W-1:0] NOP_INST   = 16'h0000;
    localparam logic [3:0]        HLT_OPCODE = 4'hF;
    localparam logic [PC_W-1:0]   PC_INC     = 16'd2;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } fetch_state_t;

    // Tag is stored full-width so the struct does not depend on BTB depth.
    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   tag;
        logic [PC_W-1:0]   target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters; lookup is combinational,
// update lands on the clock edge so a same-index lookup sees the old entry.
module branch_target_buffer
    import wisc_fetch_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   i_lk_pc,
    output logic              o_lk_hit,
    output logic [CTR_W-1:0]  o_lk_ctr,
    output logic [PC_W-1:0]   o_lk_target,
    input  logic              i_upd_en,
    input  logic [PC_W-1:0]   i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [PC_W-1:0]   i_upd_target
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t r_entries [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [PC_W-1:0]  w_lk_tag;
    logic [PC_W-1:0]  w_upd_tag;
    btb_entry_t       w_lk_entry;
    btb_entry_t       w_upd_old;
    btb_entry_t       w_upd_new;

    assign w_lk_idx   = i_lk_pc[IDX_W:1];
    assign w_upd_idx  = i_upd_pc[IDX_W:1];
    assign w_lk_tag   = PC_W'(i_lk_pc >> (IDX_W + 1));
    assign w_upd_tag  = PC_W'(i_upd_pc >> (IDX_W + 1));
    assign w_lk_entry = r_entries[w_lk_idx];
    assign w_upd_old  = r_entries[w_upd_idx];

    assign o_lk_hit    = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
    assign o_lk_ctr    = o_lk_hit ? w_lk_entry.ctr : 2'b00;
    assign o_lk_target = o_lk_hit ? w_lk_entry.target : 16'h0000;

    always_comb begin
        w_upd_new        = w_upd_old;
        w_upd_new.valid  = 1'b1;
        w_upd_new.tag    = w_upd_tag;
        w_upd_new.target = i_upd_target;
        if (w_upd_old.valid && (w_upd_old.tag == w_upd_tag)) begin
            if (i_upd_taken && (w_upd_old.ctr != 2'b11)) begin
                w_upd_new.ctr = w_upd_old.ctr + 2'b01;
            end else if (!i_upd_taken && (w_upd_old.ctr != 2'b00)) begin
                w_upd_new.ctr = w_upd_old.ctr - 2'b01;
            end
        end else begin
            w_upd_new.ctr = i_upd_taken ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
        end else if (i_upd_en) begin
            r_entries[w_upd_idx] <= w_upd_new;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, RUN/MISS I-cache sequencer and BTB-based next-PC select.
// Optional HLT freeze is enabled by defining FETCH_HALT_EN.
module instr_fetch_unit
    import wisc_fetch_pkg::*;
#(
    parameter int unsigned     BTB_ENTRIES = 8,
    parameter logic [PC_W-1:0] PC_RESET    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              btb_upd_en,
    input  logic [PC_W-1:0]   btb_upd_pc,
    input  logic              btb_upd_taken,
    input  logic [PC_W-1:0]   btb_upd_target,
    output logic              icache_rd,
    output logic [PC_W-1:0]   icache_addr,
    input  logic              icache_hit,
    input  logic [INST_W-1:0] icache_inst,
    input  logic              icache_fill_done,
    output logic [PC_W-1:0]   PC_curr,
    output logic [PC_W-1:0]   PC_next,
    output logic [INST_W-1:0] PC_inst,
    output logic [CTR_W-1:0]  prediction,
    output logic [PC_W-1:0]   predicted_target,
    output logic              fetch_miss_stall,
    output logic              halted
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic             w_fetch_ok;
    logic             w_btb_hit;
    logic             w_freeze;

    branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_lk_pc      (r_pc),
        .o_lk_hit     (w_btb_hit),
        .o_lk_ctr     (prediction),
        .o_lk_target  (predicted_target),
        .i_upd_en     (btb_upd_en),
        .i_upd_pc     (btb_upd_pc),
        .i_upd_taken  (btb_upd_taken),
        .i_upd_target (btb_upd_target)
    );

    assign w_fetch_ok       = (r_state == RUN) && icache_hit;
    assign icache_rd        = (r_state == RUN);
    assign icache_addr      = r_pc;
    assign PC_curr          = r_pc;
    assign PC_next          = r_pc + PC_INC;
    assign PC_inst          = w_fetch_ok ? icache_inst : NOP_INST;
    assign fetch_miss_stall = !w_fetch_ok;

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_halt_set;

    assign w_halt_set = w_fetch_ok && (icache_inst[15:12] == HLT_OPCODE) && !redirect;
    assign w_freeze   = r_halted || w_halt_set;
    assign halted     = r_halted;

    // Sticky once a HLT is fetched; only a redirect (or reset) releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (redirect) begin
            r_halted <= 1'b0;
        end else if (w_halt_set) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_freeze = 1'b0;
    assign halted   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= PC_RESET;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // An in-flight fill is never aborted: a redirect in MISS moves the PC but waits for fill_done.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            RUN:     if (!icache_hit && !redirect) w_state_next = MISS;
            MISS:    if (icache_fill_done)         w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
        if (redirect) begin
            w_pc_next = redirect_pc;
        end else if (!w_fetch_ok || stall || w_freeze) begin
            w_pc_next = r_pc;
        end else if (w_btb_hit && prediction[1]) begin
            w_pc_next = predicted_target;
        end else begin
            w_pc_next = r_pc + PC_INC;
        end
    end

endmodule
